// File: rtl/frame_sched_pkg.sv
// Shared types, default geometry and width helpers for the frame line scheduler.
package frame_sched_pkg;

    typedef enum logic [1:0] {IDLE, ARB, LINE, DRAIN} schedState_t;

    localparam int DEF_IMG_WIDTH   = 512;
    localparam int DEF_IMG_HEIGHT  = 512;
    localparam int DEF_PRIME_LINES = 4;
    localparam int DEF_PAD_LINES   = 2;
    localparam int DEF_DATA_W      = 12;

    localparam int TOTAL_LINES = DEF_IMG_HEIGHT + DEF_PAD_LINES;
    localparam int FRAME_PIX   = DEF_IMG_WIDTH * DEF_IMG_HEIGHT;

    // Bits needed to hold any value in 0..maxVal.
    function automatic int cntWidth(input int maxVal);
        return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/line_credit_counter.sv
// Turns datapath interrupts into line credits: rising-edge detect, saturating
// credit count and a sticky overflow error.
module line_credit_counter #(
    parameter int PRIME_LINES = 4,
    parameter int CREDIT_W    = 3
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                enable,
    input  logic                intr,
    input  logic                consume,
    output logic [CREDIT_W-1:0] credit,
    output logic                err
);

    logic intrPrev;
    logic intrEvent;

    assign intrEvent = intr && !intrPrev;

    // An event and a consume on the same cycle cancel; an event at full credit means
    // the datapath freed a buffer we never filled, which is flagged rather than counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            intrPrev <= 1'b0;
            credit   <= '0;
            err      <= 1'b0;
        end else begin
            intrPrev <= intr;
            if (load) begin
                credit <= CREDIT_W'(PRIME_LINES);
                err    <= 1'b0;
            end else if (enable) begin
                if (intrEvent && !consume) begin
                    if (credit == CREDIT_W'(PRIME_LINES))
                        err <= 1'b1;
                    else
                        credit <= credit + CREDIT_W'(1);
                end else if (consume && !intrEvent) begin
                    credit <= credit - CREDIT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/frame_line_scheduler.sv
// Feeds one frame line-by-line into the line-buffer/kernel datapath under credit
// control, appends zero pad lines, and reports when the whole image has returned.
module frame_line_scheduler
    import frame_sched_pkg::*;
#(
    parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT  = DEF_IMG_HEIGHT,
    parameter int PRIME_LINES = DEF_PRIME_LINES,
    parameter int PAD_LINES   = DEF_PAD_LINES,
    parameter int DATA_W      = DEF_DATA_W
)(
    input  logic              axi_clk,
    input  logic              axi_reset,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_err,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              o_pix_valid,
    output logic [DATA_W-1:0] o_pix_data,
    input  logic              i_dp_ready,
    input  logic              i_dp_intr,
    input  logic              i_out_valid
);

    localparam int FRAME_LINES  = IMG_HEIGHT + PAD_LINES;
    localparam int FRAME_PIXELS = IMG_WIDTH * IMG_HEIGHT;
    localparam int COL_W        = cntWidth(IMG_WIDTH - 1);
    localparam int LINE_W       = cntWidth(FRAME_LINES);
    localparam int CREDIT_W     = cntWidth(PRIME_LINES);
    localparam int OUT_W        = cntWidth(FRAME_PIXELS);

    schedState_t         state;
    logic [COL_W-1:0]    col;
    logic [LINE_W-1:0]   linesSent;
    logic [OUT_W-1:0]    outCnt;
    logic [OUT_W-1:0]    outCntNext;
    logic [CREDIT_W-1:0] creditCount;

    logic imagePhase;
    logic stageFree;
    logic beat;
    logic linesDone;
    logic consume;
    logic startFrame;

    assign imagePhase = linesSent < LINE_W'(IMG_HEIGHT);
    assign stageFree  = !o_pix_valid || i_dp_ready;
    assign beat       = (state == LINE) && stageFree && (imagePhase ? s_valid : 1'b1);
    assign s_ready    = (state == LINE) && imagePhase && stageFree;
    assign linesDone  = linesSent == LINE_W'(FRAME_LINES);
    assign consume    = (state == ARB) && !linesDone && (creditCount != '0);
    assign startFrame = (state == IDLE) && i_start;
    assign o_busy     = state != IDLE;

    assign outCntNext = ((state != IDLE) && i_out_valid && (outCnt != OUT_W'(FRAME_PIXELS)))
                        ? outCnt + OUT_W'(1) : outCnt;

    line_credit_counter #(
        .PRIME_LINES (PRIME_LINES),
        .CREDIT_W    (CREDIT_W)
    ) creditUnit (
        .clk     (axi_clk),
        .reset   (axi_reset),
        .load    (startFrame),
        .enable  (state != IDLE),
        .intr    (i_dp_intr),
        .consume (consume),
        .credit  (creditCount),
        .err     (o_err)
    );

    // Frame sequencer. The frame-done pulse is raised once in DRAIN and the return
    // to IDLE follows a cycle later, so the pulse fires even if the image finished
    // returning before the pad lines were out.
    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            state        <= IDLE;
            col          <= '0;
            linesSent    <= '0;
            outCnt       <= '0;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            outCnt       <= outCntNext;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        col       <= '0;
                        linesSent <= '0;
                        outCnt    <= '0;
                        state     <= ARB;
                    end
                end
                ARB: begin
                    if (linesDone)
                        state <= DRAIN;
                    else if (creditCount != '0)
                        state <= LINE;
                end
                LINE: begin
                    if (beat) begin
                        if (col == COL_W'(IMG_WIDTH - 1)) begin
                            col       <= '0;
                            linesSent <= linesSent + LINE_W'(1);
                            state     <= ARB;
                        end else begin
                            col <= col + COL_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (o_frame_done)
                        state <= IDLE;
                    else if (outCntNext == OUT_W'(FRAME_PIXELS))
                        o_frame_done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Single-register output stage; holds data and valid while the datapath stalls.
    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            o_pix_valid <= 1'b0;
            o_pix_data  <= '0;
        end else if (stageFree) begin
            o_pix_valid <= beat;
            if (beat)
                o_pix_data <= imagePhase ? s_data : '0;
        end
    end

endmodule

// File: tb/tb_frame_line_scheduler.sv
// Directed bench for frame_line_scheduler on an 8x6 image with 4 prime lines and 2 pad lines.
module tb_frame_line_scheduler;
    import frame_sched_pkg::*;

    localparam int W     = 8;
    localparam int H     = 6;
    localparam int PRIME = 4;
    localparam int PAD   = 2;
    localparam int DW    = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          busy;
    logic          frameDone;
    logic          err;
    logic          sValid = 1'b1;
    logic [DW-1:0] sData = '0;
    logic          sReady;
    logic          pixValid;
    logic [DW-1:0] pixData;
    logic          dpReady = 1'b1;
    logic          dpIntr = 1'b0;
    logic          outValid = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int upCnt = 0;
    logic [DW-1:0] sent[$];
    logic [DW-1:0] recv[$];
    int upCycle[$];

    frame_line_scheduler #(
        .IMG_WIDTH   (W),
        .IMG_HEIGHT  (H),
        .PRIME_LINES (PRIME),
        .PAD_LINES   (PAD),
        .DATA_W      (DW)
    ) dut (
        .axi_clk      (clk),
        .axi_reset    (reset),
        .i_start      (start),
        .o_busy       (busy),
        .o_frame_done (frameDone),
        .o_err        (err),
        .s_valid      (sValid),
        .s_data       (sData),
        .s_ready      (sReady),
        .o_pix_valid  (pixValid),
        .o_pix_data   (pixData),
        .i_dp_ready   (dpReady),
        .i_dp_intr    (dpIntr),
        .i_out_valid  (outValid)
    );

    always #5 clk = ~clk;

    // Upstream source counts up by one per accepted beat; both handshakes are logged.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (sValid && sReady) begin
                sent.push_back(sData);
                upCycle.push_back(cyc);
                upCnt++;
            end
            if (pixValid && dpReady)
                recv.push_back(pixData);
            #1 sData = DW'(upCnt);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clearLogs();
        sent.delete();
        recv.delete();
        upCycle.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        checks++; if (frameDone !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", frameDone); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b want 0", err); end
        checks++; if (sReady !== 1'b0) begin errors++; $display("[TB] FAIL reset_sready: got %b want 0", sReady); end
        checks++; if (pixValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_pixvalid: got %b want 0", pixValid); end
        checks++; if (pixData !== '0) begin errors++; $display("[TB] FAIL reset_pixdata: got %0d want 0", pixData); end
        checks++; if (dut.state !== IDLE) begin errors++; $display("[TB] FAIL reset_state: got %0d want IDLE", dut.state); end
        reset = 1'b0;
        tick(2);
        checks++; if (sReady !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_hold: sready=%b busy=%b want 0/0", sReady, busy); end
    endtask

    task automatic test_prime();
        int t = 0;
        int span;
        int gap;
        int inLine;
        clearLogs();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        while (upCnt < 32 && t < 200) begin tick(1); t++; end
        tick(10);
        span   = (upCycle.size() >= 32) ? upCycle[31] - upCycle[0] : -1;
        gap    = (upCycle.size() >= 9) ? upCycle[8] - upCycle[7] : -1;
        inLine = (upCycle.size() >= 8) ? upCycle[7] - upCycle[0] : -1;
        checks++; if (upCnt !== 32) begin errors++; $display("[TB] FAIL prime_beats: got %0d want 32", upCnt); end
        checks++; if (recv.size() !== 32) begin errors++; $display("[TB] FAIL prime_recv: got %0d want 32", recv.size()); end
        checks++; if (span !== 34) begin errors++; $display("[TB] FAIL prime_span: got %0d want 34", span); end
        checks++; if (gap !== 2) begin errors++; $display("[TB] FAIL prime_bubble: got %0d want 2", gap); end
        checks++; if (inLine !== 7) begin errors++; $display("[TB] FAIL prime_inline: got %0d want 7", inLine); end
        checks++; if (sReady !== 1'b0) begin errors++; $display("[TB] FAIL prime_sready: got %b want 0", sReady); end
        checks++; if (dut.state !== ARB) begin errors++; $display("[TB] FAIL prime_state: got %0d want ARB", dut.state); end
        checks++; if (dut.creditCount !== 3'd0) begin errors++; $display("[TB] FAIL prime_credit: got %0d want 0", dut.creditCount); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL prime_busy: got %b want 1", busy); end
    endtask

    task automatic test_backpressure();
        int t = 0;
        dpIntr = 1'b1;
        tick(1);
        dpIntr = 1'b0;
        while (upCnt < 35 && t < 100) begin tick(1); t++; end
        dpReady = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pixValid !== 1'b1 || pixData !== DW'(34) || sReady !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_hold[%0d]: valid=%b data=%0d sready=%b want 1/34/0", i, pixValid, pixData, sReady);
            end
            if (i < 3) tick(1);
        end
        dpReady = 1'b1;
        t = 0;
        while (upCnt < 40 && t < 100) begin tick(1); t++; end
        tick(10);
        checks++; if (upCnt !== 40) begin errors++; $display("[TB] FAIL release_one: got %0d want 40", upCnt); end
        dpIntr = 1'b1;
        tick(5);
        dpIntr = 1'b0;
        tick(20);
        checks++; if (upCnt !== 48) begin errors++; $display("[TB] FAIL release_level: got %0d want 48", upCnt); end
        checks++; if (dut.creditCount !== 3'd0) begin errors++; $display("[TB] FAIL release_credit: got %0d want 0", dut.creditCount); end
    endtask

    task automatic test_pad_done();
        int t = 0;
        int bad = 0;
        int nonZero = 0;
        int sawReady = 0;
        int earlyDone = 0;
        for (int i = 0; i < recv.size() && i < 48; i++)
            if (recv[i] !== DW'(i)) bad++;
        checks++; if (bad !== 0 || recv.size() !== 48) begin errors++; $display("[TB] FAIL image_seq: bad=%0d size=%0d want 0/48", bad, recv.size()); end
        dpIntr = 1'b1; tick(1); dpIntr = 1'b0;
        tick(2);
        dpIntr = 1'b1; tick(1); dpIntr = 1'b0;
        while (recv.size() < 64 && t < 100) begin
            if (sReady) sawReady++;
            tick(1);
            t++;
        end
        for (int i = 48; i < recv.size(); i++)
            if (recv[i] !== '0) nonZero++;
        checks++; if (recv.size() !== 64) begin errors++; $display("[TB] FAIL pad_count: got %0d want 64", recv.size()); end
        checks++; if (nonZero !== 0) begin errors++; $display("[TB] FAIL pad_zero: got %0d nonzero want 0", nonZero); end
        checks++; if (sawReady !== 0 || upCnt !== 48) begin errors++; $display("[TB] FAIL pad_sready: ready=%0d up=%0d want 0/48", sawReady, upCnt); end
        tick(3);
        checks++; if (dut.state !== DRAIN) begin errors++; $display("[TB] FAIL drain_state: got %0d want DRAIN", dut.state); end
        outValid = 1'b1;
        for (int i = 0; i < 47; i++) begin
            tick(1);
            if (frameDone) earlyDone++;
        end
        checks++; if (earlyDone !== 0) begin errors++; $display("[TB] FAIL done_early: got %0d pulses want 0", earlyDone); end
        tick(1);
        outValid = 1'b0;
        checks++; if (frameDone !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL done_pulse: done=%b busy=%b want 1/1", frameDone, busy); end
        tick(1);
        checks++; if (frameDone !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL done_after: done=%b busy=%b want 0/0", frameDone, busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL frame_err: got %b want 0", err); end
    endtask

    task automatic test_saturation();
        int t = 0;
        start = 1'b1; tick(1); start = 1'b0;
        tick(1);
        checks++; if (dut.creditCount !== 3'd3) begin errors++; $display("[TB] FAIL sat_first: got %0d want 3", dut.creditCount); end
        dpIntr = 1'b1; tick(1);
        checks++; if (dut.creditCount !== 3'd4 || err !== 1'b0) begin errors++; $display("[TB] FAIL sat_fill: credit=%0d err=%b want 4/0", dut.creditCount, err); end
        dpIntr = 1'b0; tick(1);
        dpIntr = 1'b1; tick(1);
        dpIntr = 1'b0;
        checks++; if (dut.creditCount !== 3'd4 || err !== 1'b1) begin errors++; $display("[TB] FAIL sat_over: credit=%0d err=%b want 4/1", dut.creditCount, err); end
        start = 1'b1; tick(1); start = 1'b0;
        checks++; if (err !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL start_ignored: err=%b busy=%b want 1/1", err, busy); end
        while (!(dut.state == ARB && dut.creditCount == 3'd1) && t < 200) begin tick(1); t++; end
        dpIntr = 1'b1; tick(1); dpIntr = 1'b0;
        checks++; if (dut.creditCount !== 3'd1 || dut.state !== LINE) begin errors++; $display("[TB] FAIL simul: credit=%0d state=%0d want 1/LINE", dut.creditCount, dut.state); end
    endtask

    task automatic test_reset_midframe();
        int t = 0;
        int base;
        int bad = 0;
        reset = 1'b1; tick(1); reset = 1'b0;
        clearLogs();
        base = upCnt;
        start = 1'b1; tick(1); start = 1'b0;
        while (upCnt - base < 28 && t < 200) begin tick(1); t++; end
        reset = 1'b1;
        tick(1);
        checks++; if (busy !== 1'b0 || sReady !== 1'b0 || pixValid !== 1'b0 || pixData !== '0 || err !== 1'b0 || frameDone !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_out: busy=%b srdy=%b pv=%b pd=%0d err=%b done=%b want all 0", busy, sReady, pixValid, pixData, err, frameDone);
        end
        checks++; if (dut.state !== IDLE) begin errors++; $display("[TB] FAIL midreset_state: got %0d want IDLE", dut.state); end
        reset = 1'b0;
        tick(2);
        clearLogs();
        start = 1'b1; tick(1); start = 1'b0;
        t = 0;
        while (sent.size() < 32 && t < 200) begin tick(1); t++; end
        tick(10);
        for (int i = 0; i < recv.size() && i < sent.size(); i++)
            if (recv[i] !== sent[i]) bad++;
        checks++; if (sent.size() !== 32 || recv.size() !== 32) begin errors++; $display("[TB] FAIL replay_count: sent=%0d recv=%0d want 32/32", sent.size(), recv.size()); end
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL replay_data: got %0d mismatched want 0", bad); end
        checks++; if (dut.state !== ARB) begin errors++; $display("[TB] FAIL replay_state: got %0d want ARB", dut.state); end
    endtask

    initial begin
        test_reset();
        test_prime();
        test_backpressure();
        test_pad_done();
        test_saturation();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_line_scheduler.md
Name: frame_line_scheduler

Overview:
- Sequences one full frame into the image-process datapath (line buffers plus 3x3 kernel) using credits. Replaces the hand-written feed sequence currently in benches.
- Primes PRIME_LINES lines, then releases one further line per datapath interrupt. After the last image line it sends PAD_LINES zero lines to flush the kernel window.
- Counts datapath output pixels and pulses frame-done when the whole image has returned.
- Sits between an upstream pixel stream (DMA/AXI-Stream source) and the datapath slave port.

Parameters:
- IMG_WIDTH, 512, pixels per line.
- IMG_HEIGHT, 512, image lines taken from upstream.
- PRIME_LINES, 4, line-buffer count; initial credits.
- PAD_LINES, 2, zero lines appended after the image.
- DATA_W, 12, pixel width (INTEGER_BITS+FIXED_POINT_BITS = 8+4).

Ports:
- axi_clk, in, 1: single clock; all logic on rising edge.
- axi_reset, in, 1: synchronous, active-high reset.
- i_start, in, 1: one-cycle frame start; ignored unless IDLE.
- o_busy, out, 1: high in any state other than IDLE.
- o_frame_done, out, 1: one-cycle pulse on the cycle the last output pixel is counted.
- o_err, out, 1: sticky; set by an interrupt while credits are at maximum. Cleared by reset or i_start.
- s_valid, in, 1: upstream pixel valid.
- s_data, in, DATA_W: upstream pixel.
- s_ready, out, 1: upstream ready.
- o_pix_valid, out, 1: datapath i_data_valid.
- o_pix_data, out, DATA_W: datapath i_data.
- i_dp_ready, in, 1: datapath o_data_ready.
- i_dp_intr, in, 1: datapath o_intr; one line buffer freed.
- i_out_valid, in, 1: datapath output beat accepted (o_data_valid AND i_data_ready).

Behaviour:
- Reset values:
  - Outputs: o_busy=0, o_frame_done=0, o_err=0, s_ready=0, o_pix_valid=0, o_pix_data=0.
  - State IDLE; all counters 0.
  - intr edge register 0.
- Reset asserted mid-frame aborts immediately; no pad lines are sent.
- Counters:
  - col: 0..IMG_WIDTH-1.
  - lines_sent: 0..IMG_HEIGHT+PAD_LINES.
  - credit: 0..PRIME_LINES.
  - out_cnt: 0..IMG_WIDTH*IMG_HEIGHT.
- Interrupt handling:
  - Rising edge of i_dp_intr (registered compare) = one credit event.
  - A level held high counts once.
- Output stage: single register.
  - Load when (!o_pix_valid || i_dp_ready) and a beat is available.
  - Otherwise hold data and valid stable (AXI rule).
  - A beat is a transfer into the stage. col increments per beat.
- FSM:
  - IDLE:
    - On i_start: credit:=PRIME_LINES; lines_sent, col, out_cnt := 0; o_err:=0. Go to ARB.
  - ARB:
    - If lines_sent == IMG_HEIGHT+PAD_LINES, go to DRAIN.
    - Else if credit > 0: credit decrements by 1, go to LINE.
    - Else stay in ARB.
  - LINE:
    - Image phase (lines_sent < IMG_HEIGHT): s_ready = (!o_pix_valid || i_dp_ready). Beat = s_valid && s_ready; stage loads s_data.
    - Pad phase: s_ready=0. Beat = stage free; stage loads 0.
    - On the beat with col==IMG_WIDTH-1: col:=0, lines_sent++, go to ARB.
    - ARB adds one bubble cycle between lines; the datapath requires this gap.
  - DRAIN:
    - s_ready=0. Wait until out_cnt == IMG_WIDTH*IMG_HEIGHT.
    - On the cycle out_cnt reaches it, pulse o_frame_done and go to IDLE.
- Credit arithmetic each cycle: credit_next = credit + intr_event − consume.
  - Simultaneous event and consume: net unchanged.
  - Event while credit == PRIME_LINES and no consume: credit stays saturated; o_err:=1.
- out_cnt:
  - Increments on i_out_valid in any non-IDLE state.
  - Saturates at IMG_WIDTH*IMG_HEIGHT.
  - Ignored in IDLE.
- s_ready is 0 in IDLE, ARB and DRAIN.
- i_start outside IDLE is ignored.

Decomposition:
- Package frame_sched_pkg holds:
  - state enum {IDLE, ARB, LINE, DRAIN};
  - localparams TOTAL_LINES = IMG_HEIGHT+PAD_LINES, FRAME_PIX = IMG_WIDTH*IMG_HEIGHT;
  - counter widths via $clog2.
- One sub-module, line_credit_counter: edge-detect, saturating credit and the o_err flag.
- Rest is flat.

Test Plan (W=8, H=6, PRIME=4, PAD=2, i_dp_ready=1, s_valid=1 unless noted):
- Prime: i_start, no intr -> exactly 32 beats with 3 one-cycle bubbles. Then credit=0, FSM holds in ARB, s_ready=0.
- Credit release: one intr pulse -> exactly 8 more beats (line 5). Intr held high 5 cycles -> still only one line released.
- Pad and done:
  - Drive 4 intrs -> lines 5–6 carry upstream data; lines 7–8 carry o_pix_data=0 with s_ready=0.
  - Assert i_out_valid 48 times -> o_frame_done pulses one cycle on the 48th; o_busy falls the next cycle.
- Backpressure: i_dp_ready low 3 cycles mid-line -> o_pix_data/o_pix_valid stable, s_ready=0, no pixel lost or duplicated. Compare sequence against upstream counter 0..47.
- Saturation/simultaneity:
  - Intr while credit=4 -> o_err=1, credit stays 4.
  - Intr on the same cycle as consume at credit=1 -> credit stays 1.
- Reset mid-frame: axi_reset at line 3, col 4 -> next cycle all outputs at reset values, state IDLE. A new i_start replays a clean frame.
